piso_buffer: RTL and testbench
==============================

// Module: piso_buffer
// PURPOSE
//   Parallel-in serial-out buffer: counterpart of the sipo buffer. Captures up to LENGTH
//   words in one load cycle, gated by a per-slot mask, then drains them one per
//   handshake, lowest index first, on a valid/ready port.
//   Sits where a wide producer (line fill, multi-issue retire) feeds a one-word consumer.
// PARAMETERS
//   WIDTH   32  bits per word.
//   LENGTH  8   number of slots; >=2, power of 2 (elaborate-time $error otherwise).
// PORTS
//   clk         in   1                    clock.
//   rst         in   1                    reset, asynchronous, active-high.
//   ld          in   1                    load strobe.
//   ld_mask     in   LENGTH               slots of d_inp that are valid.
//   d_inp       in   LENGTH x WIDTH       parallel data (packed [LENGTH-1:0][WIDTH-1:0]).
//   ld_ready    out  1                    load is accepted this cycle.
//   d_oup       out  WIDTH                current output word.
//   oup_idx     out  $clog2(LENGTH)       slot index of d_oup.
//   oup_valid   out  1                    d_oup/oup_idx valid.
//   oup_ready   in   1                    consumer takes the word this cycle.
//   pend        out  LENGTH               slots still to be sent.
//   busy        out  1                    state == DRAIN.
// BEHAVIOUR
//   Reset: state=IDLE, pend=0, data regs=0, oup_valid=0, d_oup=0, oup_idx=0, busy=0,
//   ld_ready=1. Reset mid-drain discards all pending words; nothing is emitted after rst.
//   FSM: IDLE, DRAIN.
//     IDLE : ld_ready=1. If ld & |ld_mask, capture d_inp into data, set pend<=ld_mask,
//            go to DRAIN. If ld & ~|ld_mask, the load is ignored and state stays IDLE.
//     DRAIN: oup_valid=1. d_oup=data[k] and oup_idx=k, k = lowest set bit of pend.
//            On oup_valid&oup_ready, clear pend[k]. If pend had one bit set, go to IDLE,
//            unless a load is accepted in the same cycle (see below).
//   Latency: load accepted at edge N gives oup_valid=1 and the first word in cycle N+1.
//   Output stability: d_oup, oup_idx and oup_valid come only from registered state and
//   stay stable while oup_valid & ~oup_ready.
//   Back-to-back: in DRAIN, ld_ready = (pend has exactly 1 bit) & oup_ready, a comb path
//     from oup_ready to ld_ready. A load in that cycle overwrites data and sets pend<=ld_mask.
//     State stays DRAIN, so there is no bubble. If that load has ld_mask==0, go to IDLE.
//   ld while ld_ready=0: ignored. No data corruption, pend unchanged. The producer must hold ld.
//   Skipped slots: bits clear in ld_mask are never emitted. Their data regs may be written
//   but are don't-care.
//   Throughput: 1 word per cycle while oup_ready=1. popcount(ld_mask) handshakes per load.
//   pend reflects registered state. busy = (state==DRAIN) = oup_valid.
// STRUCTURE
//   Shared package rb_pkg: typedef logic [LENGTH-1:0] slot_mask_t per instance via
//     parameterised class/let is not required. Put the state enum
//     typedef enum logic {PISO_IDLE, PISO_DRAIN} piso_state_t in rb_pkg.
//   Sub-module lsb_priority_encoder #(WIDTH=LENGTH): inp[LENGTH] -> idx, any.
//     Lowest-set-bit wins. Pure comb. Reusable by sipo free-slot search.
//   Single always_ff with async reset (posedge clk, posedge rst). Output mux is always_comb.
// TESTING
//   1 Reset: assert rst mid-drain with pend=8'hF0 -> next cycle pend=0, oup_valid=0,
//     ld_ready=1, busy=0. No further words out.
//   2 Full load: ld_mask=8'hFF, d_inp[i]=32'hA0+i, oup_ready=1 -> words A0..A7 with
//     oup_idx 0..7 on 8 consecutive cycles, first one cycle after load. Then IDLE.
//   3 Sparse load: ld_mask=8'b1010_0100 -> exactly 3 words, idx 2,5,7, in that order.
//     ld_mask=0 -> no state change, oup_valid stays 0.
//   4 Backpressure: ld_mask=8'h03, hold oup_ready=0 for 5 cycles -> d_oup=data[0],
//     oup_idx=0 held stable. ld asserted meanwhile is ignored (ld_ready=0) and pend stays 8'h03.
//   5 Back-to-back: on the last pop of load A (mask 8'h80), present load B (mask 8'h01,
//     d_inp[0]=32'hBEEF) -> ld_ready=1 that cycle. Next cycle d_oup=32'hBEEF, idx 0,
//     with no idle cycle between.
//   6 Random: random ld, masks and oup_ready, 10k cycles -> output stream equals a scoreboard
//     of masked slots in ascending index order. No drops, no duplicates.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared types for the reorder/serialisation buffers (piso/sipo).
// Holds the piso FSM state encoding and default geometry.
package rb_pkg;

    typedef enum logic {PISO_IDLE, PISO_DRAIN} piso_state_t;

    localparam int RB_WIDTH_DEF  = 32;
    localparam int RB_LENGTH_DEF = 8;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Lowest-set-bit priority encoder: idx of lowest 1 in inp, any = |inp.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of inp.
module lsb_priority_encoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         inp,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     any
);

    localparam int IW = $clog2(WIDTH);

    // Scan from the top down so the lowest set bit is the last write and wins.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (inp[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign any = |inp;

endmodule

// File: rtl/piso_buffer.sv
// Parallel-in serial-out buffer: masked LENGTH-word load, drained lowest slot first.
// Latency: first word valid the cycle after the load edge, then one word per handshake.
// Backpressure: holds output stable while oup_ready=0; ld_ready only when empty or on last pop.
module piso_buffer
    import rb_pkg::*;
#(
    parameter int WIDTH  = RB_WIDTH_DEF,
    parameter int LENGTH = RB_LENGTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld,
    input  logic [LENGTH-1:0]             ld_mask,
    input  logic [LENGTH-1:0][WIDTH-1:0]  d_inp,
    output logic                          ld_ready,
    output logic [WIDTH-1:0]              d_oup,
    output logic [$clog2(LENGTH)-1:0]     oup_idx,
    output logic                          oup_valid,
    input  logic                          oup_ready,
    output logic [LENGTH-1:0]             pend,
    output logic                          busy
);

    localparam int IW = $clog2(LENGTH);

    generate
        if (LENGTH < 2 || (LENGTH & (LENGTH - 1)) != 0) begin : g_bad_length
            $error("piso_buffer: LENGTH must be a power of 2 and >= 2");
        end
    endgenerate

    piso_state_t                  state_q, state_d;
    logic [LENGTH-1:0]            pend_q, pend_d;
    logic [LENGTH-1:0][WIDTH-1:0] data_q;
    logic                         data_we;

    logic [IW-1:0]     k;
    logic              pend_any;
    logic              pend_single;
    logic              pop;
    logic              ld_acc;
    logic [LENGTH-1:0] k_onehot;

    lsb_priority_encoder #(
        .WIDTH (LENGTH)
    ) u_enc (
        .inp (pend_q),
        .idx (k),
        .any (pend_any)
    );

    assign pend_single = pend_any && ((pend_q & (pend_q - LENGTH'(1))) == '0);
    assign k_onehot    = LENGTH'(1) << k;

    assign oup_valid = (state_q == PISO_DRAIN);
    assign busy      = oup_valid;
    assign pop       = oup_valid & oup_ready;

    // Accepting a load on the final pop keeps the output stream gap-free.
    assign ld_ready  = (state_q == PISO_IDLE) | (pend_single & pop);
    assign ld_acc    = ld & ld_ready;

    always_comb begin
        pend_d  = pend_q;
        data_we = 1'b0;
        if (pop) begin
            pend_d = pend_q & ~k_onehot;
        end
        if (ld_acc) begin
            pend_d  = ld_mask;
            data_we = |ld_mask;
        end
        state_d = (pend_d != '0) ? PISO_DRAIN : PISO_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PISO_IDLE;
            pend_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (data_we) begin
                data_q <= d_inp;
            end
        end
    end

    always_comb begin
        d_oup   = '0;
        oup_idx = '0;
        if (oup_valid) begin
            d_oup   = data_q[k];
            oup_idx = k;
        end
    end

    assign pend = pend_q;

endmodule

// File: tb/tb_piso_buffer.sv
// Self-checking bench for piso_buffer: directed scenarios plus a random run
// against a queue-based model of the emitted word stream.
module tb_piso_buffer;

    localparam int WIDTH  = 32;
    localparam int LENGTH = 8;
    localparam int IW     = 3;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         ld;
    logic [LENGTH-1:0]            ld_mask;
    logic [LENGTH-1:0][WIDTH-1:0] d_inp;
    logic                         ld_ready;
    logic [WIDTH-1:0]             d_oup;
    logic [IW-1:0]                oup_idx;
    logic                         oup_valid;
    logic                         oup_ready;
    logic [LENGTH-1:0]            pend;
    logic                         busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct packed {
        logic [IW-1:0]    idx;
        logic [WIDTH-1:0] dat;
    } word_t;

    word_t mq[$];

    piso_buffer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .ld_mask   (ld_mask),
        .d_inp     (d_inp),
        .ld_ready  (ld_ready),
        .d_oup     (d_oup),
        .oup_idx   (oup_idx),
        .oup_valid (oup_valid),
        .oup_ready (oup_ready),
        .pend      (pend),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic m_ld_ready();
        return (mq.size() == 0) || (mq.size() == 1 && oup_ready);
    endfunction

    function automatic logic [LENGTH-1:0] m_pend();
        logic [LENGTH-1:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].idx] = 1'b1;
        return p;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic l, input logic [LENGTH-1:0] m,
                         input logic [LENGTH-1:0][WIDTH-1:0] d, input logic r);
        @(negedge clk);
        ld = l; ld_mask = m; d_inp = d; oup_ready = r;
        #1;
    endtask

    // Advance one rising edge and apply the stream rules to the model.
    task automatic tick();
        logic acc;
        logic popm;
        acc  = ld && m_ld_ready();
        popm = (mq.size() > 0) && oup_ready;
        @(posedge clk);
        if (popm) void'(mq.pop_front());
        if (acc) begin
            mq.delete();
            for (int i = 0; i < LENGTH; i++)
                if (ld_mask[i]) mq.push_back({IW'(i), d_inp[i]});
        end
    endtask

    task automatic test_reset();
        logic [LENGTH-1:0][WIDTH-1:0] d;
        rst = 1'b1; ld = 1'b0; ld_mask = '0; d_inp = '0; oup_ready = 1'b0;
        #12;
        chk_cnt++; if ({oup_valid, busy, ld_ready, pend, d_oup, oup_idx} !== {1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 3'd0})
            $display("FAIL reset_state: got v=%0b b=%0b r=%0b p=%h d=%h i=%0d", oup_valid, busy, ld_ready, pend, d_oup, oup_idx);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        // Mid-drain reset with pend = F0
        for (int i = 0; i < LENGTH; i++) d[i] = 32'h100 + i;
        drive(1'b1, 8'hF0, d, 1'b0); tick();
        drive(1'b0, 8'h00, d, 1'b0);
        chk_cnt++; if (pend !== 8'hF0) $display("FAIL reset_pre_pend: got %h expected f0", pend); else pass_cnt++;
        rst = 1'b1; mq.delete();
        @(posedge clk); #1;
        chk_cnt++; if ({pend, oup_valid, ld_ready, busy} !== {8'h00, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_mid_drain: got p=%h v=%0b r=%0b b=%0b expected 00 0 1 0", pend, oup_valid, ld_ready, busy);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 8'h00, d, 1'b1);
            chk_cnt++; if (oup_valid !== 1'b0) $display("FAIL reset_no_words: got oup_valid=%0b expected 0", oup_valid); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_full_load();
        logic [LENGTH-1:0][WIDTH-1:0] d;
        for (int i = 0; i < LENGTH; i++) d[i] = 32'hA0 + i;
        drive(1'b1, 8'hFF, d, 1'b1);
        chk_cnt++; if ({ld_ready, oup_valid} !== 2'b10) $display("FAIL full_pre: got r=%0b v=%0b expected 1 0", ld_ready, oup_valid); else pass_cnt++;
        tick();
        for (int i = 0; i < LENGTH; i++) begin
            drive(1'b0, 8'h00, '0, 1'b1);
            chk_cnt++;
            if (oup_valid !== 1'b1 || d_oup !== 32'hA0 + i || oup_idx !== IW'(i))
                $display("FAIL full_word%0d: got v=%0b d=%h i=%0d expected 1 %h %0d", i, oup_valid, d_oup, oup_idx, 32'hA0 + i, i);
            else pass_cnt++;
            tick();
        end
        drive(1'b0, 8'h00, '0, 1'b1);
        chk_cnt++; if ({oup_valid, busy, ld_ready} !== 3'b001) $display("FAIL full_idle: got v=%0b b=%0b r=%0b expected 0 0 1", oup_valid, busy, ld_ready); else pass_cnt++;
    endtask

    task automatic test_sparse();
        logic [LENGTH-1:0][WIDTH-1:0] d;
        int exp_idx[3] = '{2, 5, 7};
        for (int i = 0; i < LENGTH; i++) d[i] = $urandom;
        drive(1'b1, 8'b1010_0100, d, 1'b1); tick();
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 8'h00, '0, 1'b1);
            chk_cnt++;
            if (oup_valid !== 1'b1 || oup_idx !== IW'(exp_idx[n]) || d_oup !== d[exp_idx[n]])
                $display("FAIL sparse_word%0d: got v=%0b i=%0d d=%h expected 1 %0d %h", n, oup_valid, oup_idx, d_oup, exp_idx[n], d[exp_idx[n]]);
            else pass_cnt++;
            tick();
        end
        drive(1'b1, 8'h00, d, 1'b1);
        chk_cnt++; if (oup_valid !== 1'b0) $display("FAIL sparse_done: got oup_valid=%0b expected 0", oup_valid); else pass_cnt++;
        tick();
        drive(1'b0, 8'h00, d, 1'b1);
        chk_cnt++; if ({oup_valid, pend, busy} !== {1'b0, 8'h00, 1'b0})
            $display("FAIL zero_mask: got v=%0b p=%h b=%0b expected 0 00 0", oup_valid, pend, busy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [LENGTH-1:0][WIDTH-1:0] d, d2;
        for (int i = 0; i < LENGTH; i++) begin d[i] = $urandom; d2[i] = $urandom; end
        drive(1'b1, 8'h03, d, 1'b0); tick();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 8'hFF, d2, 1'b0);
            chk_cnt++;
            if ({oup_valid, ld_ready} !== 2'b10 || d_oup !== d[0] || oup_idx !== 3'd0 || pend !== 8'h03)
                $display("FAIL bp_hold%0d: got v=%0b r=%0b d=%h i=%0d p=%h expected 1 0 %h 0 03", c, oup_valid, ld_ready, d_oup, oup_idx, pend, d[0]);
            else pass_cnt++;
            tick();
        end
        for (int n = 0; n < 2; n++) begin
            drive(1'b0, 8'h00, '0, 1'b1);
            chk_cnt++;
            if (oup_valid !== 1'b1 || d_oup !== d[n] || oup_idx !== IW'(n))
                $display("FAIL bp_drain%0d: got v=%0b d=%h i=%0d expected 1 %h %0d", n, oup_valid, d_oup, oup_idx, d[n], n);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [LENGTH-1:0][WIDTH-1:0] a, b;
        a = '0; b = '0;
        a[7] = 32'hCAFE; b[0] = 32'hBEEF;
        drive(1'b1, 8'h80, a, 1'b1); tick();
        drive(1'b1, 8'h01, b, 1'b1);
        chk_cnt++;
        if ({oup_valid, ld_ready} !== 2'b11 || d_oup !== 32'hCAFE || oup_idx !== 3'd7)
            $display("FAIL b2b_last: got v=%0b r=%0b d=%h i=%0d expected 1 1 cafe 7", oup_valid, ld_ready, d_oup, oup_idx);
        else pass_cnt++;
        tick();
        drive(1'b0, 8'h00, '0, 1'b1);
        chk_cnt++;
        if (oup_valid !== 1'b1 || d_oup !== 32'hBEEF || oup_idx !== 3'd0)
            $display("FAIL b2b_next: got v=%0b d=%h i=%0d expected 1 beef 0", oup_valid, d_oup, oup_idx);
        else pass_cnt++;
        tick();
        drive(1'b0, 8'h00, '0, 1'b1);
        chk_cnt++; if (oup_valid !== 1'b0) $display("FAIL b2b_idle: got oup_valid=%0b expected 0", oup_valid); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [LENGTH-1:0][WIDTH-1:0] d;
        logic [LENGTH-1:0]            m;
        int errs = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < LENGTH; i++) d[i] = $urandom;
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : LENGTH'($urandom);
            drive(1'($urandom_range(0, 1)), m, d, 1'($urandom_range(0, 9) < 7));
            chk_cnt++;
            if (oup_valid !== (mq.size() > 0) || busy !== (mq.size() > 0) || ld_ready !== m_ld_ready() || pend !== m_pend()) begin
                if (errs++ < 10)
                    $display("FAIL rand_ctrl@%0d: got v=%0b b=%0b r=%0b p=%h expected v=%0b r=%0b p=%h", c, oup_valid, busy, ld_ready, pend, mq.size() > 0, m_ld_ready(), m_pend());
            end else pass_cnt++;
            if (mq.size() > 0) begin
                chk_cnt++;
                if (d_oup !== mq[0].dat || oup_idx !== mq[0].idx) begin
                    if (errs++ < 10)
                        $display("FAIL rand_word@%0d: got d=%h i=%0d expected d=%h i=%0d", c, d_oup, oup_idx, mq[0].dat, mq[0].idx);
                end else pass_cnt++;
            end
            tick();
        end
        for (int c = 0; c < LENGTH + 2; c++) begin
            drive(1'b0, 8'h00, '0, 1'b1); tick();
        end
        drive(1'b0, 8'h00, '0, 1'b1);
        chk_cnt++;
        if (oup_valid !== 1'b0 || mq.size() != 0)
            $display("FAIL rand_drained: got v=%0b model_left=%0d expected 0 0", oup_valid, mq.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
